// File: rtl/locked_reg_pkg.sv
// Shared types and default sizing for the locked register bank.
//   dbg_state_t  : debug FSM state (DBG_OFF / DBG_ON)
//   DEF_*        : default parameter values used by the interface and modules
package locked_reg_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_NUM_REGS = 8;
  localparam int unsigned DEF_VCNT_W   = 8;

  typedef enum logic {
    DBG_OFF = 1'b0,
    DBG_ON  = 1'b1
  } dbg_state_t;

endpackage

// File: rtl/locked_register_bank_if.sv
// Bus bundle for the locked register bank.
//   master : agent side (drives write/read/lock/debug/clear requests)
//   slave  : bank side (returns read data, lock status, debug and violation state)
interface locked_register_bank_if
  import locked_reg_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned VCNT_W   = DEF_VCNT_W
);

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic                lock_en;
  logic [NUM_REGS-1:0] lock_mask;
  logic [NUM_REGS-1:0] lock_status;
  logic                trusted;
  logic                debug_mode;
  logic                dbg_active;
  logic                viol_clr;
  logic                viol_pulse;
  logic                viol_sticky;
  logic [VCNT_W-1:0]   viol_count;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, lock_en, lock_mask,
           trusted, debug_mode, viol_clr,
    input  rd_data, rd_valid, lock_status, dbg_active, viol_pulse, viol_sticky, viol_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, lock_en, lock_mask,
           trusted, debug_mode, viol_clr,
    output rd_data, rd_valid, lock_status, dbg_active, viol_pulse, viol_sticky, viol_count
  );

endinterface

// File: rtl/lock_viol_counter.sv
// Saturating violation counter with sticky flag and trusted-only clear.
//   Clk, resetn : clock, asynchronous active-low reset
//   viol        : one violation this cycle
//   clr         : clear request, honoured only with trusted high
//   trusted     : trusted-agent qualifier
//   count       : saturating violation count
//   sticky      : set on any violation, cleared by trusted clear
module lock_viol_counter
  import locked_reg_pkg::*;
#(
  parameter int unsigned VCNT_W = DEF_VCNT_W
) (
  input  logic              Clk,
  input  logic              resetn,
  input  logic              viol,
  input  logic              clr,
  input  logic              trusted,
  output logic [VCNT_W-1:0] count,
  output logic              sticky
);

  logic [VCNT_W-1:0] count_q, count_d;
  logic              sticky_q, sticky_d;
  logic              clr_ok;

  assign clr_ok = clr & trusted;

  always_comb begin
    count_d  = count_q;
    sticky_d = sticky_q;
    if (clr_ok) begin
      // A violation in the clearing cycle survives as the first new count.
      count_d  = VCNT_W'(viol);
      sticky_d = viol;
    end else if (viol) begin
      if (!(&count_q)) count_d = count_q + VCNT_W'(1);
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  assign count  = count_q;
  assign sticky = sticky_q;

endmodule

// File: rtl/locked_register_bank.sv
// Register bank with sticky per-register write locks, a trusted debug override
// and violation tracking for rejected writes.
//   Clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : write/read ports, lock request/status, debug request/status,
//                 violation pulse/sticky/count and trusted clear
module locked_register_bank
  import locked_reg_pkg::*;
#(
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter int unsigned       NUM_REGS  = DEF_NUM_REGS,
  parameter int unsigned       ADDR_W    = $clog2(NUM_REGS),
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int unsigned       VCNT_W    = DEF_VCNT_W
) (
  input logic                   Clk,
  input logic                   resetn,
  locked_register_bank_if.slave bus
);

  dbg_state_t          state_q, state_d;
  logic                dbg_on;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] lock_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic                viol_pulse_q;
  logic [31:0]         wr_addr_ext, rd_addr_ext;
  logic                wr_in_range, rd_in_range, wr_locked, wr_accept, wr_viol;

  // Addresses widened so the range test also works when NUM_REGS is not a power of two.
  assign wr_addr_ext = 32'(bus.wr_addr);
  assign rd_addr_ext = 32'(bus.rd_addr);
  assign wr_in_range = wr_addr_ext < NUM_REGS;
  assign rd_in_range = rd_addr_ext < NUM_REGS;

  // Debug FSM: state register.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) state_q <= DBG_OFF;
    else         state_q <= state_d;
  end

  // Debug FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DBG_OFF: if (bus.debug_mode && bus.trusted)   state_d = DBG_ON;
      DBG_ON:  if (!bus.debug_mode || !bus.trusted) state_d = DBG_OFF;
      default: state_d = DBG_OFF;
    endcase
  end

  // Debug FSM: outputs. Writes are judged against the current state, so debug
  // entry only takes effect one cycle after debug_mode & trusted rise.
  always_comb begin
    dbg_on = (state_q == DBG_ON);
  end

  assign wr_locked = wr_in_range && lock_q[bus.wr_addr];
  assign wr_accept = bus.wr_en && wr_in_range && (!wr_locked || dbg_on);
  assign wr_viol   = bus.wr_en && !wr_accept;

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else if (wr_accept) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Locks only ever accumulate; a same-cycle write still sees the old lock.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) lock_q <= '0;
    else         lock_q <= lock_q | ({NUM_REGS{bus.lock_en}} & bus.lock_mask);
  end

  // Read samples regs_q before any same-edge write lands, returning the old value.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= rd_in_range ? regs_q[bus.rd_addr] : '0;
    end
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) viol_pulse_q <= 1'b0;
    else         viol_pulse_q <= wr_viol;
  end

  lock_viol_counter #(
    .VCNT_W (VCNT_W)
  ) u_viol_counter (
    .Clk     (Clk),
    .resetn  (resetn),
    .viol    (wr_viol),
    .clr     (bus.viol_clr),
    .trusted (bus.trusted),
    .count   (bus.viol_count),
    .sticky  (bus.viol_sticky)
  );

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.lock_status = lock_q;
  assign bus.dbg_active  = dbg_on;
  assign bus.viol_pulse  = viol_pulse_q;

endmodule

// File: doc/locked_register_bank.md
LOCKED_REGISTER_BANK -- requirements
Module: locked_register_bank

Interface
REQ-001 Parameter DATA_W, default 16, data width of each register.
REQ-002 Parameter NUM_REGS, default 8, register count (2..64).
REQ-003 Parameter ADDR_W, default $clog2(NUM_REGS), address width.
REQ-004 Parameter RESET_VAL, default all-zero DATA_W vector, per-register reset value.
REQ-005 Parameter VCNT_W, default 8, violation counter width.
REQ-006 Clk  in  1  clock, all state updates on the rising edge.
REQ-007 resetn  in  1  reset, asynchronous, active-low.
REQ-008 wr_en  in  1  write request.
REQ-009 wr_addr  in  ADDR_W  write address.
REQ-010 wr_data  in  DATA_W  write data.
REQ-011 rd_en  in  1  read request.
REQ-012 rd_addr  in  ADDR_W  read address.
REQ-013 rd_data  out  DATA_W  registered read data.
REQ-014 rd_valid  out  1  rd_data qualifier.
REQ-015 lock_en  in  1  lock request.
REQ-016 lock_mask  in  NUM_REGS  per-register lock select.
REQ-017 lock_status  out  NUM_REGS  current sticky lock bits.
REQ-018 trusted  in  1  trusted-agent qualifier.
REQ-019 debug_mode  in  1  debug request.
REQ-020 dbg_active  out  1  debug FSM in DBG_ON.
REQ-021 viol_clr  in  1  violation clear request.
REQ-022 viol_pulse  out  1  one-cycle rejected-write flag.
REQ-023 viol_sticky  out  1  sticky violation flag.
REQ-024 viol_count  out  VCNT_W  saturating violation count.

Function
REQ-025 lock_status[i] SHALL set on the edge where lock_en & lock_mask[i], and SHALL never clear except by resetn; lock_en with lock_mask zero SHALL have no effect.
REQ-026 Debug FSM SHALL have states DBG_OFF and DBG_ON: DBG_OFF->DBG_ON when debug_mode & trusted; DBG_ON->DBG_OFF when ~debug_mode | ~trusted; otherwise hold.
REQ-027 A write SHALL be accepted when wr_en, wr_addr < NUM_REGS, and (~lock_status[wr_addr] | state==DBG_ON), all sampled before the edge; the register updates on that edge.
REQ-028 Debug entry SHALL take one cycle: a write in the same cycle debug_mode & trusted first rise SHALL be judged against DBG_OFF.
REQ-029 Write and lock to the same register in the same cycle: write SHALL be accepted and the lock SHALL apply from the next cycle.
REQ-030 A write SHALL be rejected and flagged as a violation when wr_en and (wr_addr >= NUM_REGS or (lock_status[wr_addr] & state==DBG_OFF)).
REQ-031 viol_pulse SHALL assert for exactly the cycle after each violation; viol_sticky SHALL set on the same edge.
REQ-032 viol_count SHALL increment by one per violation and saturate at 2^VCNT_W-1.
REQ-033 viol_clr SHALL clear viol_count and viol_sticky only when trusted is high; viol_clr without trusted SHALL be ignored.
REQ-034 A trusted viol_clr coinciding with a violation SHALL yield viol_count=1 and viol_sticky=1.
REQ-035 Reads SHALL have one-cycle latency: rd_valid follows rd_en by one cycle; rd_data holds the addressed value, or zero for rd_addr >= NUM_REGS.
REQ-036 A read and an accepted write to the same address in the same cycle SHALL return the old value.
REQ-037 rd_data SHALL hold its last value while rd_valid is low.

Reset
REQ-038 On resetn low, regardless of Clk, all registers SHALL load RESET_VAL; lock_status, rd_data, rd_valid, viol_pulse, viol_sticky, and viol_count SHALL be zero; the FSM SHALL enter DBG_OFF.
REQ-039 Reset asserted mid-operation SHALL discard any in-flight read or write; the first post-reset edge SHALL use reset state.

Structure
REQ-040 Package locked_reg_pkg SHALL hold the dbg_state_t enum (DBG_OFF, DBG_ON) and default parameter constants.
REQ-041 Sub-module lock_viol_counter SHALL implement the VCNT_W saturating counter, its sticky flag, and trusted clear.

Verification
REQ-042 Write 0xA5A5 to reg 3, read reg 3 -> rd_data=0xA5A5 with rd_valid one cycle after rd_en.
REQ-043 Lock reg 3 with lock_mask=0x08, write 0x1234 -> reg unchanged, viol_pulse one cycle, viol_count=1, viol_sticky=1.
REQ-044 debug_mode=1 with trusted=0, write locked reg 3 -> rejected; raise trusted, wait one cycle, write 0x5555 -> accepted, no violation.
REQ-045 Write to addr NUM_REGS -> violation; 300 violations with VCNT_W=8 -> viol_count=255.
REQ-046 viol_clr without trusted -> no change; trusted viol_clr in the same cycle as a violation -> viol_count=1.
REQ-047 Assert resetn mid-burst with regs locked -> all lock_status=0, registers=RESET_VAL, FSM=DBG_OFF.
